rotleft_seq: RTL and testbench
==============================

# rotleft_seq

Multi-cycle rotate-left engine for 32-bit words. It undoes the fixed right rotations applied in the hash datapath; for example, rotating left by 6 restores the input of the Σ1 rotate-right-by-6 stage. The block takes a word and a rotation amount through a valid/ready handshake and applies one binary-weighted rotation step per clock, LSB of the amount first. It then holds the result under output backpressure. It serves the self-check and debug path that reconstructs pre-rotation words, where area matters more than single-cycle latency.

## Interface
- WIDTH, 32, word width; must be a power of two ≥ 2
- AMT_W, $clog2(WIDTH), rotation-amount width (derived; do not override)
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  inp/amt are valid
- in_ready  output  1  block can accept a request this cycle
- inp  input  WIDTH  word to rotate
- amt  input  AMT_W  left-rotation amount, 0..WIDTH-1
- out_valid  output  1  res holds a finished result
- out_ready  input  1  consumer accepts res this cycle
- res  output  WIDTH  rotated word

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - ROT: in_ready=0, out_valid=0.
  - HOLD: out_valid=1, in_ready=out_ready.
- Accept: in_valid && in_ready at a clock edge.
  - Captures inp into work register W and amt into register A.
  - Clears step index k to 0 and enters ROT.
- ROT, each edge:
  - If A[k]=1, W ← rotl(W, 2^k), else W unchanged.
  - k increments.
  - After k=AMT_W-1 the next state is HOLD.
- HOLD:
  - res=W, stable until the handshake completes.
  - On out_valid && out_ready: if in_valid also high in that cycle, accept the new request (go to ROT); otherwise go to IDLE.
- Arithmetic: pure bit permutation, no carries. rotl(x,n) = (x<<n) | (x>>(WIDTH-n)) within WIDTH bits.
- amt=0 is legal: the word passes through unchanged with full latency. There is no short-circuit.
- Outputs in IDLE and ROT:
  - res shows W, but is don't-care to the consumer while out_valid=0.
- Reset, including mid-ROT or mid-HOLD:
  - Next cycle: state=IDLE, in_ready=1, out_valid=0, res=0, W=0, A=0, k=0.
  - The in-flight result is discarded and never presented.
- in_valid during ROT is ignored (in_ready=0). Upstream must hold its request.

## Timing
- Latency: request accepted at edge E0 → out_valid high in the cycle after edge E(AMT_W). That is 5 cycles for WIDTH=32.
- Throughput: one result per AMT_W+1 cycles with out_ready held high. Back-to-back acceptance happens in the HOLD handshake cycle.
- All outputs are registered or decoded from state only.
  - No combinational path from out_ready to res or out_valid.
  - in_ready depends combinationally on out_ready in HOLD only.
- After rst deasserts, in_ready is 1 in the first cycle.

## Structure
- Shared package rot_pkg:
  - WORD_W=32
  - typedef rot_state_t enum {IDLE, ROT, HOLD}
  - function rotl(word, n)
- Sub-module rotleft_step: combinational; input word, step index k, enable bit; output word rotated left by 2^k when enabled. Instantiated once and muxed by k.
- Top level holds the FSM, the W/A/k registers and the handshake logic.

## Test plan
- inp=0x00000001, amt=6, out_ready=1 → out_valid exactly 5 cycles after acceptance, res=0x00000040.
- Round trip: inp=0xE048D159 (0x12345678 rotated right 6), amt=6 → res=0x12345678.
- inp=0x80000000, amt=31 → res=0x40000000. inp=0xA5A5A5A5, amt=0 → res=0xA5A5A5A5 after full latency.
- Backpressure: out_ready low for 3 cycles in HOLD → res and out_valid stable, in_ready=0. When out_ready rises with in_valid high and a new request (0x0000000F, amt=4) → accepted in the same cycle; the next result is 0x000000F0.
- rst pulsed at the 3rd ROT cycle → next cycle IDLE, out_valid=0, res=0, in_ready=1. The aborted result never appears. A new request then completes normally.
- Random sweep: 1000 random inp/amt pairs with random out_ready stalls, compared against a reference rotl model. Every accepted request yields exactly one result, in order.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the multi-cycle rotate-left engine: word width, FSM
// encoding and a reference rotate helper.
package rot_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_AMT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } rot_state_t;

    // The doubled word shifted left leaves the rotated word in its upper half.
    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0]     word,
                                               input logic [WORD_AMT_W-1:0] n);
        logic [2*WORD_W-1:0] dbl;
        dbl = {word, word} << n;
        return dbl[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/rotleft_step.sv
// One binary-weighted rotate stage: rotates word_in left by 2^k when en is set.
// Shared by every step of the sequential engine, so k selects the stage weight.
module rotleft_step
    import rot_pkg::*;
#(
    parameter  int WIDTH = WORD_W,
    localparam int AMT_W = $clog2(WIDTH),
    localparam int K_W   = (AMT_W > 1) ? $clog2(AMT_W) : 1
) (
    input  logic [WIDTH-1:0] word_in,
    input  logic [K_W-1:0]   k,
    input  logic             en,
    output logic [WIDTH-1:0] word_out
);

    always_comb begin
        word_out = word_in;
        for (int i = 0; i < AMT_W; i++) begin
            if (en && (k == K_W'(i))) begin
                word_out = (word_in << (1 << i)) | (word_in >> (WIDTH - (1 << i)));
            end
        end
    end

endmodule

// File: rtl/rotleft_seq.sv
// Sequential rotate-left engine: accepts a word and amount, applies one
// power-of-two rotate per clock (amount LSB first), then holds the result.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   ROT   | stepping through amount bits k=0..AMT_W-1, no handshakes
//   HOLD  | result on res, out_valid=1, in_ready follows out_ready
module rotleft_seq
    import rot_pkg::*;
#(
    parameter  int WIDTH = WORD_W,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);

    localparam int K_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(AMT_W - 1);

    rot_state_t       state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [AMT_W-1:0] a_q, a_d;
    logic [K_W-1:0]   k_q, k_d;

    logic [WIDTH-1:0] step_word;
    logic             accept;

    rotleft_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .word_in  (w_q),
        .k        (k_q),
        .en       (a_q[k_q]),
        .word_out (step_word)
    );

    // in_ready is the only output with a combinational input dependency.
    assign out_valid = (state_q == HOLD);
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign res       = w_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        a_d     = a_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ROT;
                    w_d     = inp;
                    a_d     = amt;
                    k_d     = '0;
                end
            end
            ROT: begin
                w_d = step_word;
                k_d = k_q + K_W'(1);
                if (k_q == K_LAST) begin
                    state_d = HOLD;
                    k_d     = '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
                // Back-to-back: a new request rides the draining handshake.
                if (accept) begin
                    state_d = ROT;
                    w_d     = inp;
                    a_d     = amt;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            a_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            a_q     <= a_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_rotleft_seq.sv
// Self-checking bench for rotleft_seq: directed vector table, backpressure and
// reset corner sequences, then a randomized sweep against a bit-by-bit model.
module tb_rotleft_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inp;
    logic [4:0]  amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rotleft_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp       (inp),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    // Reference: move the top bit to the bottom n times.
    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = x;
        repeat (n) r = {r[30:0], r[31]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called right after the accepting edge; counts edges until out_valid.
    task automatic wait_result(output int lat);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready !== 1'b0) begin
                chk("in_ready_low_in_rot", {31'b0, in_ready}, 32'd0);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic send_req(input logic [31:0] x, input logic [4:0] a,
                            input logic [31:0] exp, input string name);
        int lat;
        @(negedge clk);
        inp       = x;
        amt       = a;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({name, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        wait_result(lat);
        chk({name, "_latency"}, lat, 32'd5);
        chk({name, "_res"}, res, exp);
        @(negedge clk);
        chk({name, "_drained"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    typedef struct {
        logic [31:0] inp;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lat;
        int          sent;
        int          got;
        int          cycles;
        int          ghost;
        logic        acc_last;
        logic        stall_last;
        logic [31:0] stall_res;
        logic [31:0] exp_q[$];

        vecs[0] = '{32'h0000_0001, 5'd6,  32'h0000_0040};
        vecs[1] = '{32'hE048_D159, 5'd6,  32'h1234_5678};
        vecs[2] = '{32'h8000_0000, 5'd31, 32'h4000_0000};
        vecs[3] = '{32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[4] = '{32'h0000_000F, 5'd4,  32'h0000_00F0};
        vecs[5] = '{32'h1234_5678, 5'd16, 32'h5678_1234};
        vecs[6] = '{32'h0000_0003, 5'd31, 32'h8000_0001};
        vecs[7] = '{32'h8765_4321, 5'd1,  32'h0ECA_8643};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp       = '0;
        amt       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_res", res, 32'd0);

        for (int i = 0; i < 8; i++) begin
            send_req(vecs[i].inp, vecs[i].amt, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result three cycles, then chain a new request.
        @(negedge clk);
        inp       = 32'h1234_5678;
        amt       = 5'd8;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        wait_result(lat);
        chk("bp_latency", lat, 32'd5);
        for (int c = 0; c < 3; c++) begin
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_res", res, 32'h3456_7812);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inp       = 32'h0000_000F;
        amt       = 5'd4;
        #1;
        chk("bp_in_ready_follow", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        wait_result(lat);
        chk("bp_chain_latency", lat, 32'd5);
        chk("bp_chain_res", res, 32'h0000_00F0);
        @(negedge clk);
        chk("bp_chain_drained", {31'b0, out_valid}, 32'd0);

        // Reset during the third ROT cycle discards the in-flight word.
        @(negedge clk);
        inp      = 32'hDEAD_BEEF;
        amt      = 5'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_res", res, 32'd0);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        ghost = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        chk("rst_mid_no_ghost", ghost, 32'd0);
        send_req(32'hC000_0001, 5'd2, 32'h0000_0007, "after_rst");

        // Randomized sweep with random stalls; results must arrive in order.
        sent       = 0;
        got        = 0;
        cycles     = 0;
        acc_last   = 1'b0;
        stall_last = 1'b0;
        stall_res  = '0;
        in_valid   = 1'b0;
        while (got < 1000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (acc_last) in_valid = 1'b0;
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                inp      = $urandom;
                amt      = 5'($urandom_range(0, 31));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_last) begin
                chk("rand_stall_valid", {31'b0, out_valid}, 32'd1);
                chk("rand_stall_res", res, stall_res);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_result", {31'b0, out_valid}, 32'd0);
                end else begin
                    chk("rand_res", res, exp_q.pop_front());
                end
                got++;
            end
            stall_last = out_valid && !out_ready;
            stall_res  = res;
            acc_last   = in_valid && in_ready;
            if (acc_last) begin
                exp_q.push_back(ref_rotl(inp, int'(amt)));
                sent++;
            end
        end
        chk("rand_all_results", got, 32'd1000);
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
